updown_mod_counter: RTL and testbench
=====================================

// Module: updown_mod_counter
//
// PURPOSE
//   Parametrised modulo-N up/down counter. Supports count enable, synchronous
//   parallel load, terminal-count detect and a registered wrap pulse. It is the
//   general-purpose successor to the fixed 4-bit free-running up counter, and
//   serves as the timebase/event counter for clock dividers, timers and
//   sequencers in the design.
//
// PARAMETERS
//   WIDTH      8    count register width in bits (>=2)
//   MODULO     256  count range 0..MODULO-1; legal 2..2**WIDTH
//   RESET_VAL  0    count value after reset; must be < MODULO
//
// PORTS
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous, active-high reset
//   en        in   1      count enable: step by one per cycle when high
//   up_dn     in   1      direction: 1 = up, 0 = down
//   load      in   1      synchronous parallel load strobe
//   load_val  in   WIDTH  value captured when load=1
//   count     out  WIDTH  current count (registered)
//   tc        out  1      terminal count (combinational from count/up_dn)
//   wrap      out  1      one-cycle registered pulse on wrap (or on a blocked step in saturate mode)
//
// BEHAVIOUR
//   - Clock and reset: single clock domain. Reset is synchronous and active-high.
//     All state updates on posedge clk.
//   - Priority per edge: reset > load > en > hold.
//   - Reset: count <= RESET_VAL, wrap <= 0. tc follows combinationally.
//     Asserting reset mid-count discards any load or en in the same cycle.
//   - Load: count <= load_val, wrap <= 0. en is ignored in that cycle.
//     - If load_val >= MODULO, count <= MODULO-1 (clamp; no X, no wrap).
//   - Enabled step, up (en=1, up_dn=1):
//     - count == MODULO-1 -> count <= 0, wrap <= 1.
//     - else -> count <= count+1, wrap <= 0.
//   - Enabled step, down (en=1, up_dn=0):
//     - count == 0 -> count <= MODULO-1, wrap <= 1.
//     - else -> count <= count-1, wrap <= 0.
//   - Hold (en=0, no load): count unchanged, wrap <= 0.
//   - Pulse width: wrap is high for exactly one cycle, coincident with the
//     post-wrap count value. Consecutive wraps (e.g. MODULO=2) give back-to-back
//     pulses.
//   - tc = up_dn ? (count == MODULO-1) : (count == 0), independent of en.
//     A direction change takes effect on tc the same cycle and on count at the
//     next enabled edge.
//   - Arithmetic: unsigned, WIDTH bits. Compares use a WIDTH-bit MODULO-1
//     constant. When MODULO == 2**WIDTH, wrap is natural overflow but must still
//     be detected by compare.
//   - Latency: load and step are visible on count one cycle after the edge.
//     No combinational path from any input to count or wrap.
//   - Parameter check: MODULO outside 2..2**WIDTH, or RESET_VAL >= MODULO, is
//     rejected at elaboration.
//
// CONFIGURATION
//   - COUNTER_SATURATE_EN defined: saturating counter.
//     - Up at MODULO-1, or down at 0: count holds and wrap <= 1 for one cycle,
//       flagging a blocked step.
//     - wrap re-asserts on every blocked enabled cycle.
//     - tc is unchanged. Load and clamp behaviour are unchanged.
//   - COUNTER_SATURATE_EN undefined: wrap-around behaviour exactly as above.
//
// TESTING  (WIDTH=4, MODULO=10, RESET_VAL=0 unless stated)
//   1. reset=1 for 2 clks, en=1 -> count=0, wrap=0, tc=0 (up). Release reset,
//      en=1 up for 12 clks -> 0,1,...,9,0,1,2. wrap=1 only with the count=0
//      after 9. tc=1 while count=9.
//   2. load=1, load_val=5, en=1 same cycle -> count=5 (load wins). Then down
//      6 clks -> 4,3,2,1,0,9. wrap=1 with the 9. tc=1 while count=0.
//   3. load_val=13 (>=MODULO) -> count=9. load_val=15 -> count=9. No wrap pulse.
//   4. en=0 for 5 clks at count=7 -> count stays 7, wrap=0. Toggle up_dn at
//      count=0 -> tc flips 0->1 the same cycle.
//   5. Mid-count at count=6 with en=1, load=1 -> assert reset same cycle ->
//      next count=0, wrap=0. Repeat with RESET_VAL=3 -> count=3.
//   6. COUNTER_SATURATE_EN: up from 8 for 4 clks -> 9,9,9,9, wrap=1 on the 3
//      blocked cycles. Down from 1 -> 0,0, wrap=1 on the 2nd. Also MODULO=16,
//      non-saturate: 15 -> 0 with wrap=1.

Source files
------------

// File: rtl/updown_mod_counter.sv
// Parametrised modulo-N up/down counter with load, terminal-count and wrap pulse.
// Define COUNTER_SATURATE_EN to hold at the range ends instead of wrapping.
module updown_mod_counter #(
  parameter int WIDTH     = 8,
  parameter int MODULO    = 256,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);

  generate
    if ((WIDTH < 2) || (MODULO < 2) ||
        ((WIDTH < 31) && (MODULO > (1 << WIDTH))) ||
        (RESET_VAL < 0) || (RESET_VAL >= MODULO)) begin : g_bad_params
      $error("updown_mod_counter: illegal WIDTH/MODULO/RESET_VAL combination");
    end
  endgenerate

  logic [WIDTH-1:0] next_count;
  logic             next_wrap;
  logic             at_top;
  logic             at_bot;

  // Range ends are found by compare so MODULO == 2**WIDTH behaves like any other modulus.
  assign at_top = (count == MAX_VAL);
  assign at_bot = (count == '0);
  assign tc     = up_dn ? at_top : at_bot;

  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (load) begin
      next_count = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (at_top) begin
`ifdef COUNTER_SATURATE_EN
          next_count = count;
`else
          next_count = '0;
`endif
          next_wrap  = 1'b1;
        end else begin
          next_count = count + 1'b1;
        end
      end else begin
        if (at_bot) begin
`ifdef COUNTER_SATURATE_EN
          next_count = count;
`else
          next_count = MAX_VAL;
`endif
          next_wrap  = 1'b1;
        end else begin
          next_count = count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RST_VAL;
      wrap  <= 1'b0;
    end else begin
      count <= next_count;
      wrap  <= next_wrap;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: three instances (mod 10, mod 10 reset 3, mod 16)
// checked each cycle against an arithmetic model, plus literal scenario checks.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       reset, en, up_dn, load;
  logic [3:0] load_val;
  logic [3:0] cnt [3];
  logic       wr  [3];
  logic       tcs [3];

  int checks = 0;
  int errors = 0;

  int mod_of [3] = '{10, 10, 16};
  int rv_of  [3] = '{0, 3, 0};
  int m_cnt  [3];
  int m_wrap [3];
  bit m_valid = 1'b0;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MODULO(10), .RESET_VAL(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(cnt[0]), .tc(tcs[0]), .wrap(wr[0]));
  updown_mod_counter #(.WIDTH(4), .MODULO(10), .RESET_VAL(3)) dut1 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(cnt[1]), .tc(tcs[1]), .wrap(wr[1]));
  updown_mod_counter #(.WIDTH(4), .MODULO(16), .RESET_VAL(0)) dut2 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(cnt[2]), .tc(tcs[2]), .wrap(wr[2]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: count as an integer in 0..mod-1, stepped by plain arithmetic.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_cnt[i]  = rv_of[i];
        m_wrap[i] = 0;
      end else if (load) begin
        m_cnt[i]  = (int'(load_val) >= mod_of[i]) ? mod_of[i] - 1 : int'(load_val);
        m_wrap[i] = 0;
      end else if (en) begin
        int nxt;
        nxt = up_dn ? m_cnt[i] + 1 : m_cnt[i] - 1;
        if (nxt < 0 || nxt >= mod_of[i]) begin
          m_wrap[i] = 1;
          if (!SAT) m_cnt[i] = (nxt + mod_of[i]) % mod_of[i];
        end else begin
          m_wrap[i] = 0;
          m_cnt[i]  = nxt;
        end
      end else begin
        m_wrap[i] = 0;
      end
    end
    if (reset) m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_count[%0d]", i), int'(cnt[i]), m_cnt[i]);
        chk($sformatf("model_wrap[%0d]", i), int'(wr[i]), m_wrap[i]);
        chk($sformatf("model_tc[%0d]", i), int'(tcs[i]),
            up_dn ? int'(m_cnt[i] == mod_of[i] - 1) : int'(m_cnt[i] == 0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string name, input int i, input int c, input int w, input int t);
    chk({name, "_count"}, int'(cnt[i]), c);
    chk({name, "_wrap"}, int'(wr[i]), w);
    chk({name, "_tc"}, int'(tcs[i]), t);
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; up_dn = 1'b1; load = 1'b0; load_val = '0;
    tick(); tick();
    lit("reset", 0, 0, 0, 0);
    lit("reset_rv3", 1, 3, 0, 0);

    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      int c, w;
      tick();
      if (SAT) begin c = (k > 9) ? 9 : k; w = int'(k > 9); end
      else     begin c = k % 10;          w = int'(k == 10); end
      lit("up_seq", 0, c, w, int'(c == 9));
    end

    load = 1'b1; load_val = 4'd5; up_dn = 1'b0;
    tick();
    lit("load_wins", 0, 5, 0, 0);
    load = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      int c, w;
      tick();
      c = 5 - k;
      w = 0;
      if (c < 0) begin c = SAT ? 0 : 9; w = 1; end
      lit("down_seq", 0, c, w, int'(c == 0));
    end

    en = 1'b0; load = 1'b1; load_val = 4'd13;
    tick();
    lit("clamp13", 0, 9, 0, 0);
    lit("noclamp16", 2, 13, 0, 0);
    load_val = 4'd15;
    tick();
    lit("clamp15", 0, 9, 0, 0);

    load_val = 4'd7;
    tick();
    load = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      lit("hold", 0, 7, 0, 0);
    end

    up_dn = 1'b1; load = 1'b1; load_val = 4'd0;
    tick();
    lit("tc_up_at0", 0, 0, 0, 0);
    up_dn = 1'b0;
    #1;
    chk("tc_dir_flip", int'(tcs[0]), 1);

    load_val = 4'd6;
    tick();
    en = 1'b1; load_val = 4'd2; reset = 1'b1;
    tick();
    lit("reset_over_load", 0, 0, 0, 1);
    lit("reset_over_load_rv3", 1, 3, 0, 0);
    reset = 1'b0;

    up_dn = 1'b1; load = 1'b1; load_val = 4'd8;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      int c, w;
      tick();
      if (SAT) begin c = 9; w = int'(k > 1); end
      else     begin c = (8 + k) % 10; w = int'(k == 2); end
      lit("up_top", 0, c, w, int'(c == 9));
    end

    en = 1'b0; load = 1'b1; load_val = 4'd1; up_dn = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    lit("down_to0", 0, 0, 0, 1);
    tick();
    lit("down_blocked", 0, SAT ? 0 : 9, 1, SAT ? 1 : 0);

    en = 1'b0; load = 1'b1; load_val = 4'd15; up_dn = 1'b1;
    tick();
    lit("mod16_load15", 2, 15, 0, 1);
    load = 1'b0; en = 1'b1;
    tick();
    lit("mod16_wrap", 2, SAT ? 15 : 0, 1, SAT ? 1 : 0);

    for (int k = 0; k < 500; k++) begin
      reset    = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 7) == 0);
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = ($urandom_range(0, 9) < 6);
      load_val = 4'($urandom_range(0, 15));
      tick();
    end

    reset = 1'b0; load = 1'b0; en = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
